seq3_monitor: RTL and testbench



---
 rtl/seq3_monitor.sv | 141 ++++++++++++++
 tb/tb_seq3_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq3_monitor.sv
// Passive checker for the 3-phase sequencer: tracks its state/terminal outputs,
// flags the first encoding, transition or terminal violation and counts rounds.
module seq3_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_rst,
  input  logic             pause,
  input  logic             restart,
  input  logic [1:0]       state_in,
  input  logic             terminal_in,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] round_cnt,
  output logic             round_done
);

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [1:0] S_FIRST   = 2'b11;
  localparam logic [1:0] S_SECOND  = 2'b01;
  localparam logic [1:0] S_THIRD   = 2'b10;
  localparam logic [1:0] S_ILLEGAL = 2'b00;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ENC   = 2'b01;
  localparam logic [1:0] E_TRANS = 2'b10;
  localparam logic [1:0] E_TERM  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       prev_state;
  logic             prev_pause, prev_restart, prev_seq_rst;
  logic             round_pend, pend_d;
  logic [1:0]       code_d;
  logic [CNT_W-1:0] cnt_d;
  logic             sample_d;
  logic             done_d;
  logic [1:0]       exp_next;
  logic             exp_term;

  // Legal successor of the previously sampled sequencer state.
  always_comb begin
    exp_next = S_FIRST;
    if (!prev_seq_rst) begin
      case (prev_state)
        S_FIRST:  exp_next = (prev_restart || prev_pause) ? S_FIRST : S_SECOND;
        S_SECOND: exp_next = prev_restart ? S_FIRST : (prev_pause ? S_SECOND : S_THIRD);
        S_THIRD:  exp_next = (!prev_restart && prev_pause) ? S_THIRD : S_FIRST;
        default:  exp_next = S_FIRST;
      endcase
    end
  end

  assign exp_term = (state_in == S_THIRD) && (restart || !pause);

  // Next-state and next-output logic; clr overrides every state.
  always_comb begin
    state_d  = state_q;
    code_d   = err_code;
    cnt_d    = round_cnt;
    pend_d   = 1'b0;
    sample_d = 1'b1;
    done_d   = round_pend;
    case (state_q)
      HUNT: begin
        if (state_in == S_ILLEGAL) begin
          state_d = FAULT;
          code_d  = E_ENC;
        end else if (state_in == S_FIRST) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (state_in == S_ILLEGAL) begin
          state_d = FAULT;
          code_d  = E_ENC;
        end else if (state_in != exp_next) begin
          state_d = FAULT;
          code_d  = E_TRANS;
        end else if (terminal_in != exp_term) begin
          state_d = FAULT;
          code_d  = E_TERM;
        end else if (terminal_in) begin
          pend_d = 1'b1;
          if (round_cnt != CNT_MAX) cnt_d = round_cnt + CNT_W'(1);
        end
      end
      FAULT: begin
        sample_d = 1'b0;
      end
      default: begin
        state_d = HUNT;
      end
    endcase
    if (clr) begin
      state_d = HUNT;
      code_d  = E_NONE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      prev_state   <= 2'b00;
      prev_pause   <= 1'b0;
      prev_restart <= 1'b0;
      prev_seq_rst <= 1'b0;
      round_pend   <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_code     <= E_NONE;
      round_cnt    <= '0;
      round_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_pend <= pend_d;
      locked     <= (state_d == TRACK);
      err        <= (state_d == FAULT);
      err_code   <= code_d;
      round_cnt  <= cnt_d;
      round_done <= done_d;
      if (sample_d) begin
        prev_state   <= state_in;
        prev_pause   <= pause;
        prev_restart <= restart;
        prev_seq_rst <= seq_rst;
      end
    end
  end

endmodule

// File: tb/tb_seq3_monitor.sv
// Directed bench for seq3_monitor: one instance at CNT_W=8, one at CNT_W=2 for saturation.
module tb_seq3_monitor;

  logic       clk = 1'b0;
  logic       rst, seq_rst, pause, restart, terminal_in, clr;
  logic [1:0] state_in;

  logic       locked_a, err_a, done_a;
  logic [1:0] code_a;
  logic [7:0] cnt_a;
  logic       locked_b, err_b, done_b;
  logic [1:0] code_b;
  logic [1:0] cnt_b;

  int total = 0;
  int bad = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  seq3_monitor #(.CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .seq_rst(seq_rst), .pause(pause), .restart(restart),
    .state_in(state_in), .terminal_in(terminal_in), .clr(clr),
    .locked(locked_a), .err(err_a), .err_code(code_a), .round_cnt(cnt_a), .round_done(done_a)
  );

  seq3_monitor #(.CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .seq_rst(seq_rst), .pause(pause), .restart(restart),
    .state_in(state_in), .terminal_in(terminal_in), .clr(clr),
    .locked(locked_b), .err(err_b), .err_code(code_b), .round_cnt(cnt_b), .round_done(done_b)
  );

  task automatic drive(input logic [1:0] st, input logic term, input logic p, input logic r);
    state_in    = st;
    terminal_in = term;
    pause       = p;
    restart     = r;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (done_a) pulses_a++;
    if (done_b) pulses_b++;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; seq_rst = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 1'b0);
    step();
    step();
    total++;
    if ({locked_a, err_a, code_a, cnt_a, done_a} !== 13'd0) begin
      bad++; $display("FAIL reset_a got=%b exp=0", {locked_a, err_a, code_a, cnt_a, done_a});
    end
    total++;
    if ({locked_b, err_b, code_b, cnt_b, done_b} !== 7'd0) begin
      bad++; $display("FAIL reset_b got=%b exp=0", {locked_b, err_b, code_b, cnt_b, done_b});
    end
  endtask

  task automatic test_round();
    rst = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    total++;
    if (locked_a !== 1'b1) begin bad++; $display("FAIL round_lock got=%b exp=1", locked_a); end
    drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    drive(2'b10, 1'b1, 1'b0, 1'b0); step();
    total++;
    if (cnt_a !== 8'd1 || done_a !== 1'b0) begin
      bad++; $display("FAIL round_cnt got=%0d/%b exp=1/0", cnt_a, done_a);
    end
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    total++;
    if (done_a !== 1'b1 || err_a !== 1'b0) begin
      bad++; $display("FAIL round_pulse got=%b/%b exp=1/0", done_a, err_a);
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b0, 1'b1, 1'b0); step();
    end
    total++;
    if (err_a !== 1'b0 || locked_a !== 1'b1 || done_a !== 1'b0) begin
      bad++; $display("FAIL pause_hold got=%b/%b/%b exp=0/1/0", err_a, locked_a, done_a);
    end
    drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    drive(2'b10, 1'b1, 1'b0, 1'b0); step();
    total++;
    if (err_a !== 1'b0 || cnt_a !== 8'd2) begin
      bad++; $display("FAIL pause_release got=%b/%0d exp=0/2", err_a, cnt_a);
    end
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    total++;
    if (err_a !== 1'b1 || code_a !== 2'b10 || locked_a !== 1'b0 || cnt_a !== 8'd2) begin
      bad++; $display("FAIL bad_trans got=%b/%b/%b/%0d exp=1/10/0/2", err_a, code_a, locked_a, cnt_a);
    end
    drive(2'b00, 1'b1, 1'b0, 1'b0); step();
    total++;
    if (err_a !== 1'b1 || code_a !== 2'b10) begin
      bad++; $display("FAIL fault_freeze got=%b/%b exp=1/10", err_a, code_a);
    end
  endtask

  task automatic test_clear();
    clr = 1'b1; drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    clr = 1'b0;
    total++;
    if ({locked_a, err_a, code_a, cnt_a} !== 12'd0) begin
      bad++; $display("FAIL clear got=%b exp=0", {locked_a, err_a, code_a, cnt_a});
    end
    step();
    clr = 1'b1; drive(2'b00, 1'b0, 1'b0, 1'b0); step();
    clr = 1'b0;
    total++;
    if (err_a !== 1'b0 || code_a !== 2'b00 || locked_a !== 1'b0) begin
      bad++; $display("FAIL clr_vs_violation got=%b/%b/%b exp=0/00/0", err_a, code_a, locked_a);
    end
  endtask

  task automatic test_terminal_mismatch();
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    drive(2'b10, 1'b1, 1'b0, 1'b0); step();
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    drive(2'b10, 1'b1, 1'b1, 1'b0); step();
    total++;
    if (err_a !== 1'b1 || code_a !== 2'b11 || cnt_a !== 8'd1) begin
      bad++; $display("FAIL term_mismatch got=%b/%b/%0d exp=1/11/1", err_a, code_a, cnt_a);
    end
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    total++;
    if (done_a !== 1'b0) begin bad++; $display("FAIL term_no_pulse got=%b exp=0", done_a); end
  endtask

  task automatic test_encoding();
    clr = 1'b1; step(); clr = 1'b0;
    drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    total++;
    if (locked_a !== 1'b0 || err_a !== 1'b0) begin
      bad++; $display("FAIL hunt_stay got=%b/%b exp=0/0", locked_a, err_a);
    end
    drive(2'b00, 1'b0, 1'b0, 1'b0); step();
    total++;
    if (err_a !== 1'b1 || code_a !== 2'b01) begin
      bad++; $display("FAIL hunt_enc got=%b/%b exp=1/01", err_a, code_a);
    end
    clr = 1'b1; step(); clr = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    drive(2'b00, 1'b1, 1'b0, 1'b0); step();
    total++;
    if (err_a !== 1'b1 || code_a !== 2'b01) begin
      bad++; $display("FAIL enc_priority got=%b/%b exp=1/01", err_a, code_a);
    end
    clr = 1'b1; drive(2'b11, 1'b0, 1'b0, 1'b0); step(); clr = 1'b0;
    total++;
    if (err_a !== 1'b0 || cnt_a !== 8'd0 || locked_a !== 1'b0) begin
      bad++; $display("FAIL enc_clear got=%b/%0d/%b exp=0/0/0", err_a, cnt_a, locked_a);
    end
  endtask

  task automatic test_saturation();
    pulses_a = 0; pulses_b = 0;
    drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 1'b0, 1'b0, 1'b0); step();
      drive(2'b10, 1'b1, 1'b0, 1'b0); step();
      drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    end
    total++;
    if (cnt_b !== 2'd3 || pulses_b != 5) begin
      bad++; $display("FAIL sat_narrow got=%0d/%0d exp=3/5", cnt_b, pulses_b);
    end
    total++;
    if (cnt_a !== 8'd5 || pulses_a != 5 || err_b !== 1'b0) begin
      bad++; $display("FAIL sat_wide got=%0d/%0d/%b exp=5/5/0", cnt_a, pulses_a, err_b);
    end
  endtask

  task automatic test_seq_rst();
    seq_rst = 1'b1; drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    seq_rst = 1'b0; drive(2'b11, 1'b0, 1'b0, 1'b0); step();
    total++;
    if (err_a !== 1'b0 || locked_a !== 1'b1) begin
      bad++; $display("FAIL seq_rst got=%b/%b exp=0/1", err_a, locked_a);
    end
    drive(2'b01, 1'b0, 1'b0, 1'b0); step();
    total++;
    if (err_a !== 1'b0) begin bad++; $display("FAIL seq_rst_after got=%b exp=0", err_a); end
    rst = 1'b1; step();
    total++;
    if ({locked_a, err_a, code_a, cnt_a, done_a} !== 13'd0 ||
        {locked_b, err_b, code_b, cnt_b, done_b} !== 7'd0) begin
      bad++; $display("FAIL mid_rst got=%b/%b exp=0/0",
                      {locked_a, err_a, code_a, cnt_a, done_a}, {locked_b, err_b, code_b, cnt_b, done_b});
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round();
    test_pause();
    test_clear();
    test_terminal_mismatch();
    test_encoding();
    test_saturation();
    test_seq_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
